// File: rtl/pump_alarm_annunciator.sv
// pump_alarm_annunciator
//   Debounces the six alarm lines from industrial_pump_monitor, latches the
//   qualified alarms with first-out capture, and sequences the pump through
//   IDLE / RUN / TRIP / ACKED / LOCKOUT with horn, flashing lamp and a
//   restart lockout timer.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   A1..A6         raw alarm lines, 1 = alarm
//   start_req      operator start (level)
//   stop_req       operator stop (level, wins over start)
//   ack            operator acknowledge (level, only acted on in TRIP)
//   pump_run       pump contactor command
//   horn           audible alarm
//   lamp           alarm lamp (flashes in TRIP, steady in ACKED/LOCKOUT)
//   alarm_latched  sticky qualified alarms, bit i-1 <-> Ai
//   first_out      code 1..6 of first qualified alarm, 0 = none
//   fault_active   OR of currently qualified alarms
//   lockout        high while in LOCKOUT
module pump_alarm_annunciator #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESTART_DELAY   = 1000,
    parameter int FLASH_DIV       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       A5,
    input  logic       A6,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       ack,
    output logic       pump_run,
    output logic       horn,
    output logic       lamp,
    output logic [5:0] alarm_latched,
    output logic [2:0] first_out,
    output logic       fault_active,
    output logic       lockout
);

    localparam logic [7:0]  DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] LOCK_LOAD  = 16'(RESTART_DELAY);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_TRIP,
        ST_ACKED,
        ST_LOCKOUT
    } state_t;

    logic [5:0] alarm_raw;
    assign alarm_raw = {A6, A5, A4, A3, A2, A1};

    // ---------------------------------------------------------------
    // Per-channel debounce
    // ---------------------------------------------------------------
    logic [7:0] db_cnt_reg  [6];
    logic [7:0] db_cnt_next [6];
    logic [5:0] qualified_reg;
    logic [5:0] qualified_next;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_debounce
            // Saturating count of consecutive high samples; a low sample
            // drops both the count and the qualified flag on the same edge.
            assign db_cnt_next[gi] = !alarm_raw[gi]        ? 8'd0 :
                                     (db_cnt_reg[gi] == DB_LIMIT) ? db_cnt_reg[gi] :
                                     db_cnt_reg[gi] + 8'd1;
            assign qualified_next[gi] = alarm_raw[gi] && (db_cnt_next[gi] == DB_LIMIT);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) db_cnt_reg[i] <= 8'd0;
            qualified_reg <= 6'd0;
        end else begin
            for (int i = 0; i < 6; i++) db_cnt_reg[i] <= db_cnt_next[i];
            qualified_reg <= qualified_next;
        end
    end

    assign fault_active = |qualified_reg;

    // ---------------------------------------------------------------
    // Sequencer next-state logic
    // ---------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [15:0] lock_cnt_reg, lock_cnt_next;
    logic [7:0]  flash_cnt_reg, flash_cnt_next;
    logic        flash_phase_reg, flash_phase_next;
    logic [5:0]  alarm_latched_reg, alarm_latched_next;
    logic [2:0]  first_out_reg, first_out_next;
    logic        pump_run_reg, horn_reg, lamp_reg, lockout_reg;

    logic [5:0]  newly_qualified;
    logic        clear_latch;
    logic [2:0]  first_code;

    // A channel is "new" only if it has not been latched since the last clear,
    // so repeats of a known alarm never re-sound the horn from ACKED.
    assign newly_qualified = qualified_reg & ~alarm_latched_reg;

    // Lowest index wins when several channels qualify together.
    always_comb begin
        first_code = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (qualified_reg[i]) first_code = 3'(i + 1);
        end
    end

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fault_active)               state_next = ST_TRIP;
                else if (start_req && !stop_req) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (fault_active)  state_next = ST_TRIP;
                else if (stop_req) state_next = ST_IDLE;
            end
            ST_TRIP: begin
                if (ack && (newly_qualified == 6'd0)) state_next = ST_ACKED;
            end
            ST_ACKED: begin
                if (newly_qualified != 6'd0) begin
                    state_next = ST_TRIP;
                end else if (!fault_active) begin
                    state_next    = ST_LOCKOUT;
                    lock_cnt_next = LOCK_LOAD;
                end
            end
            ST_LOCKOUT: begin
                if (fault_active) begin
                    state_next    = ST_TRIP;
                    lock_cnt_next = 16'd0;
                end else if (lock_cnt_reg <= 16'd1) begin
                    // Leaves on the edge the count reaches zero, so LOCKOUT
                    // lasts exactly RESTART_DELAY cycles.
                    state_next    = ST_IDLE;
                    lock_cnt_next = 16'd0;
                end else begin
                    lock_cnt_next = lock_cnt_reg - 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign clear_latch = (state_reg == ST_LOCKOUT) && (state_next == ST_IDLE);

    always_comb begin
        alarm_latched_next = clear_latch ? 6'd0 : (alarm_latched_reg | qualified_reg);
        first_out_next     = clear_latch ? 3'd0 :
                             (first_out_reg == 3'd0) ? first_code : first_out_reg;
    end

    // Flash divider restarts with the lamp on whenever TRIP is (re)entered.
    always_comb begin
        flash_cnt_next   = flash_cnt_reg;
        flash_phase_next = flash_phase_reg;
        if ((state_next == ST_TRIP) && (state_reg != ST_TRIP)) begin
            flash_cnt_next   = 8'd0;
            flash_phase_next = 1'b1;
        end else if (state_reg == ST_TRIP) begin
            if (flash_cnt_reg == FLASH_LAST) begin
                flash_cnt_next   = 8'd0;
                flash_phase_next = ~flash_phase_reg;
            end else begin
                flash_cnt_next = flash_cnt_reg + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            lock_cnt_reg      <= 16'd0;
            flash_cnt_reg     <= 8'd0;
            flash_phase_reg   <= 1'b0;
            alarm_latched_reg <= 6'd0;
            first_out_reg     <= 3'd0;
            pump_run_reg      <= 1'b0;
            horn_reg          <= 1'b0;
            lamp_reg          <= 1'b0;
            lockout_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            lock_cnt_reg      <= lock_cnt_next;
            flash_cnt_reg     <= flash_cnt_next;
            flash_phase_reg   <= flash_phase_next;
            alarm_latched_reg <= alarm_latched_next;
            first_out_reg     <= first_out_next;
            pump_run_reg      <= (state_next == ST_RUN);
            horn_reg          <= (state_next == ST_TRIP);
            lamp_reg          <= (state_next == ST_TRIP)  ? flash_phase_next :
                                 ((state_next == ST_ACKED) || (state_next == ST_LOCKOUT));
            lockout_reg       <= (state_next == ST_LOCKOUT);
        end
    end

    assign pump_run      = pump_run_reg;
    assign horn          = horn_reg;
    assign lamp          = lamp_reg;
    assign lockout       = lockout_reg;
    assign alarm_latched = alarm_latched_reg;
    assign first_out     = first_out_reg;

endmodule

// File: tb/tb_pump_alarm_annunciator.sv
// Testbench for pump_alarm_annunciator: directed stimulus pushes hand-computed
// expected output snapshots into a queue; an independent monitor pops and
// compares on the falling edge.
module tb_pump_alarm_annunciator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A1 = 0, A2 = 0, A3 = 0, A4 = 0, A5 = 0, A6 = 0;
    logic       start_req = 0, stop_req = 0, ack = 0;
    logic       pump_run, horn, lamp, fault_active, lockout;
    logic [5:0] alarm_latched;
    logic [2:0] first_out;

    always #5 clk = ~clk;

    pump_alarm_annunciator #(
        .DEBOUNCE_CYCLES(4),
        .RESTART_DELAY  (10),
        .FLASH_DIV      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .A4           (A4),
        .A5           (A5),
        .A6           (A6),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .ack          (ack),
        .pump_run     (pump_run),
        .horn         (horn),
        .lamp         (lamp),
        .alarm_latched(alarm_latched),
        .first_out    (first_out),
        .fault_active (fault_active),
        .lockout      (lockout)
    );

    // Snapshot layout: {pump_run, horn, lamp, alarm_latched[5:0], first_out[2:0], fault_active, lockout}
    logic [13:0] exp_q[$];
    string       name_q[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    task automatic expect_out(input string nm, input logic pr, input logic hn, input logic lp,
                              input logic [5:0] lat, input logic [2:0] fo,
                              input logic fa, input logic lo);
        exp_q.push_back({pr, hn, lp, lat, fo, fa, lo});
        name_q.push_back(nm);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e, a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pump_run, horn, lamp, alarm_latched, first_out, fault_active, lockout};
            chk_cnt++;
            if (a === e) begin
                pass_cnt++;
                $display("ok   %-16s run=%b horn=%b lamp=%b lat=%b fo=%0d fault=%b lock=%b",
                         nm, a[13], a[12], a[11], a[10:5], a[4:2], a[1], a[0]);
            end else begin
                $display("FAIL %-16s got run=%b horn=%b lamp=%b lat=%b fo=%0d fault=%b lock=%b | exp run=%b horn=%b lamp=%b lat=%b fo=%0d fault=%b lock=%b",
                         nm, a[13], a[12], a[11], a[10:5], a[4:2], a[1], a[0],
                         e[13], e[12], e[11], e[10:5], e[4:2], e[1], e[0]);
            end
        end
    end

    initial begin
        // Reset state
        step(2);
        expect_out("reset", 0, 0, 0, 6'b000000, 3'd0, 0, 0);
        step(1);
        rst_n = 1'b1;

        // stop has priority over start in IDLE
        start_req = 1; stop_req = 1;
        step(1);
        expect_out("start_stop_prio", 0, 0, 0, 6'b000000, 3'd0, 0, 0);
        stop_req = 0;
        step(1);
        expect_out("run", 1, 0, 0, 6'b000000, 3'd0, 0, 0);
        start_req = 0;

        // ack outside TRIP does nothing
        ack = 1;
        step(1);
        ack = 0;
        expect_out("ack_in_run", 1, 0, 0, 6'b000000, 3'd0, 0, 0);

        // 3-cycle glitch on A2 never qualifies
        A2 = 1;
        step(3);
        A2 = 0;
        step(3);
        expect_out("glitch", 1, 0, 0, 6'b000000, 3'd0, 0, 0);

        // A3 held: qualified after k+3, trip after k+4
        A3 = 1;
        step(4);
        expect_out("a3_qual", 1, 0, 0, 6'b000000, 3'd0, 1, 0);
        step(1);
        expect_out("a3_trip", 0, 1, 1, 6'b000100, 3'd3, 1, 0);
        step(3);
        expect_out("flash_ph1", 0, 1, 1, 6'b000100, 3'd3, 1, 0);
        step(1);
        expect_out("flash_ph2", 0, 1, 0, 6'b000100, 3'd3, 1, 0);

        // Acknowledge, then alarm drops -> LOCKOUT
        ack = 1;
        step(1);
        ack = 0;
        expect_out("acked", 0, 0, 1, 6'b000100, 3'd3, 1, 0);
        A3 = 0;
        step(1);
        expect_out("a3_drop", 0, 0, 1, 6'b000100, 3'd3, 0, 0);
        step(1);
        expect_out("lockout_entry", 0, 0, 1, 6'b000100, 3'd3, 0, 1);
        start_req = 1;
        step(9);
        expect_out("lockout_hold", 0, 0, 1, 6'b000100, 3'd3, 0, 1);
        step(1);
        expect_out("lockout_done", 0, 0, 0, 6'b000000, 3'd0, 0, 0);
        start_req = 0;

        // Simultaneous A5 + A2
        step(1);
        start_req = 1;
        step(1);
        start_req = 0;
        expect_out("run2", 1, 0, 0, 6'b000000, 3'd0, 0, 0);
        A5 = 1; A2 = 1;
        step(5);
        expect_out("dual_trip", 0, 1, 1, 6'b010010, 3'd2, 1, 0);
        ack = 1;
        step(1);
        ack = 0;
        expect_out("dual_ack", 0, 0, 1, 6'b010010, 3'd2, 1, 0);

        // A2 drops and requalifies while acknowledged: no re-sound
        A2 = 0;
        step(1);
        A2 = 1;
        step(5);
        expect_out("repeat_acked", 0, 0, 1, 6'b010010, 3'd2, 1, 0);

        // Clear, enter LOCKOUT, A6 qualifies at count 5
        A2 = 0; A5 = 0;
        step(2);
        step(1);
        A6 = 1;
        step(4);
        expect_out("a6_qual_lock", 0, 0, 1, 6'b010010, 3'd2, 1, 1);
        step(1);
        expect_out("a6_retrip", 0, 1, 1, 6'b110010, 3'd2, 1, 0);

        // Asynchronous reset mid-TRIP
        step(1);
        #2;
        rst_n = 0;
        A6 = 0;
        #1;
        expect_out("async_reset", 0, 0, 0, 6'b000000, 3'd0, 0, 0);
        step(1);
        rst_n = 1;
        start_req = 1;
        step(1);
        start_req = 0;
        expect_out("run_after_rst", 1, 0, 0, 6'b000000, 3'd0, 0, 0);

        stop_req = 1;
        step(1);
        stop_req = 0;
        expect_out("stop", 0, 0, 0, 6'b000000, 3'd0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
